// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants, stage-action codes and helpers for the inter-stage pipeline register.
package pipe_stage_reg_pkg;

    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'b00000;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        STG_RUN    = 2'd0,
        STG_HOLD   = 2'd1,
        STG_BUBBLE = 2'd2,
        STG_FLUSH  = 2'd3
    } stg_state_e;

    typedef enum logic [1:0] {
        LANE_LOAD = 2'd0,
        LANE_HOLD = 2'd1,
        LANE_NOP  = 2'd2
    } lane_op_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Decodes {rst, flush, pause} into the reported stage action and the per-lane register operation.
module pipe_stage_ctrl
    import pipe_stage_reg_pkg::*;
#(
    parameter int STAGE   = 2,
    parameter int PAUSE_W = 6
) (
    input  logic               rst,
    input  logic               flush,
    input  logic [PAUSE_W-1:0] pause,
    output stg_state_e         action,
    output lane_op_e           lane_op
);

    // The extra top bit makes the last stage see NoStop from its non-existent successor.
    logic [PAUSE_W:0] pause_ext;
    logic             here_stop;
    logic             next_stop;
    logic             unused_pause;

    assign pause_ext    = {NO_STOP, pause};
    assign here_stop    = pause_ext[STAGE];
    assign next_stop    = pause_ext[STAGE+1];
    assign unused_pause = ^pause_ext;

    always_comb begin
        action  = STG_RUN;
        lane_op = LANE_LOAD;
        if (rst == RST_ENABLE) begin
            lane_op = LANE_NOP;
        end else if (flush) begin
            action  = STG_FLUSH;
            lane_op = LANE_NOP;
        end else if (here_stop == STOP) begin
            if (next_stop == STOP) begin
                action  = STG_HOLD;
                lane_op = LANE_HOLD;
            end else begin
                action  = STG_BUBBLE;
                lane_op = LANE_NOP;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-lane inter-stage pipeline register with stall/bubble/flush handling and a stage-state output.
// Optional PIPE_STAGE_STATS_EN adds saturating hold_cnt / bubble_cnt outputs.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int DATA_W  = 75,
    parameter int STAGE   = 2,
    parameter int PAUSE_W = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PAUSE_W-1:0]      pause,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*DATA_W-1:0] in_payload,
    input  logic [LANES*5-1:0]      in_wd,
    input  logic [LANES-1:0]        in_wreg,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES*DATA_W-1:0] out_payload,
    output logic [LANES*5-1:0]      out_wd,
    output logic [LANES-1:0]        out_wreg,
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]             hold_cnt,
    output logic [31:0]             bubble_cnt,
`endif
    output logic [1:0]              stage_state
);

    stg_state_e action;
    lane_op_e   lane_op;
    stg_state_e stage_state_d;
    stg_state_e stage_state_q;

    pipe_stage_ctrl #(
        .STAGE   (STAGE),
        .PAUSE_W (PAUSE_W)
    ) u_ctrl (
        .rst     (rst),
        .flush   (flush),
        .pause   (pause),
        .action  (action),
        .lane_op (lane_op)
    );

    // Reset is folded into lane_op (decoded as NOP), so lanes clear synchronously with rst.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic              valid_d, valid_q;
        logic [DATA_W-1:0] payload_d, payload_q;
        logic [4:0]        wd_d, wd_q;
        logic              wreg_d, wreg_q;

        always_comb begin
            valid_d   = valid_q;
            payload_d = payload_q;
            wd_d      = wd_q;
            wreg_d    = wreg_q;
            case (lane_op)
                LANE_NOP: begin
                    valid_d   = 1'b0;
                    payload_d = '0;
                    wd_d      = NOP_REG_ADDR;
                    wreg_d    = WRITE_DISABLE;
                end
                LANE_HOLD: ;
                default: begin
                    valid_d   = in_valid[i];
                    payload_d = in_payload[i*DATA_W +: DATA_W];
                    wd_d      = in_wd[i*5 +: 5];
                    wreg_d    = in_valid[i] ? in_wreg[i] : WRITE_DISABLE;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
        end

        assign out_valid[i]                    = valid_q;
        assign out_payload[i*DATA_W +: DATA_W] = payload_q;
        assign out_wd[i*5 +: 5]                = wd_q;
        assign out_wreg[i]                     = wreg_q;
    end

    assign stage_state_d = action;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_state_q <= STG_RUN;
        end else begin
            stage_state_q <= stage_state_d;
        end
    end

    assign stage_state = stage_state_q;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] hold_cnt_d, hold_cnt_q;
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (action == STG_HOLD) begin
            hold_cnt_d = sat_inc32(hold_cnt_q);
        end
        if (action == STG_BUBBLE) begin
            bubble_cnt_d = sat_inc32(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q   <= ZERO_WORD;
            bubble_cnt_q <= ZERO_WORD;
        end else begin
            hold_cnt_q   <= hold_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign hold_cnt   = hold_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (STAGE=2 and STAGE=5) share stimulus;
// a spec-level model queues expected outputs, a monitor pops and compares each cycle.
module tb_pipe_stage_reg;

    localparam int LANES   = 2;
    localparam int DATA_W  = 75;
    localparam int PAUSE_W = 6;
    localparam int PW      = LANES * DATA_W;
    localparam int CW      = 2 + PW + LANES*5 + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               flush;
    logic [PAUSE_W-1:0] pause;
    logic [LANES-1:0]   in_valid;
    logic [PW-1:0]      in_payload;
    logic [LANES*5-1:0] in_wd;
    logic [LANES-1:0]   in_wreg;

    logic [LANES-1:0]   o0_valid, o1_valid;
    logic [PW-1:0]      o0_payload, o1_payload;
    logic [LANES*5-1:0] o0_wd, o1_wd;
    logic [LANES-1:0]   o0_wreg, o1_wreg;
    logic [1:0]         o0_state, o1_state;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]        o0_hold, o0_bub, o1_hold, o1_bub;
`endif

    pipe_stage_reg #(.LANES(LANES), .DATA_W(DATA_W), .STAGE(2), .PAUSE_W(PAUSE_W)) dut0 (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_wd(in_wd), .in_wreg(in_wreg),
        .out_valid(o0_valid), .out_payload(o0_payload), .out_wd(o0_wd), .out_wreg(o0_wreg),
`ifdef PIPE_STAGE_STATS_EN
        .hold_cnt(o0_hold), .bubble_cnt(o0_bub),
`endif
        .stage_state(o0_state)
    );

    pipe_stage_reg #(.LANES(LANES), .DATA_W(DATA_W), .STAGE(5), .PAUSE_W(PAUSE_W)) dut1 (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload), .in_wd(in_wd), .in_wreg(in_wreg),
        .out_valid(o1_valid), .out_payload(o1_payload), .out_wd(o1_wd), .out_wreg(o1_wreg),
`ifdef PIPE_STAGE_STATS_EN
        .hold_cnt(o1_hold), .bubble_cnt(o1_bub),
`endif
        .stage_state(o1_state)
    );

    typedef struct packed {
        logic [LANES-1:0]   v;
        logic [PW-1:0]      p;
        logic [LANES*5-1:0] wd;
        logic [LANES-1:0]   wr;
        logic [1:0]         st;
        logic [31:0]        hc;
        logic [31:0]        bc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m[2];

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: output is a NOP, a hold of the previous value, or the (masked) input, chosen by the priority rules.
    task automatic model_step(input int d, input int s);
        logic here_stop, next_stop;
        here_stop = pause[s];
        next_stop = (s == PAUSE_W-1) ? 1'b0 : pause[s+1];
        if (rst) begin
            m[d] = '0;
        end else if (flush) begin
            m[d].v = '0; m[d].p = '0; m[d].wd = '0; m[d].wr = '0;
            m[d].st = 2'd3;
        end else if (here_stop && next_stop) begin
            m[d].st = 2'd1;
            if (m[d].hc != 32'hFFFF_FFFF) m[d].hc = m[d].hc + 1;
        end else if (here_stop) begin
            m[d].v = '0; m[d].p = '0; m[d].wd = '0; m[d].wr = '0;
            m[d].st = 2'd2;
            if (m[d].bc != 32'hFFFF_FFFF) m[d].bc = m[d].bc + 1;
        end else begin
            m[d].v  = in_valid;
            m[d].p  = in_payload;
            m[d].wd = in_wd;
            m[d].wr = in_wreg & in_valid;
            m[d].st = 2'd0;
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic [PAUSE_W-1:0] pz,
                       input logic [LANES-1:0] v, input logic [PW-1:0] p,
                       input logic [LANES*5-1:0] wd, input logic [LANES-1:0] wr);
        @(negedge clk);
        rst = r; flush = f; pause = pz;
        in_valid = v; in_payload = p; in_wd = wd; in_wreg = wr;
        model_step(0, 2);
        model_step(1, 5);
        q0.push_back(m[0]);
        q1.push_back(m[1]);
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("dut0_data", {2'b00, o0_valid, o0_payload, o0_wd, o0_wreg}, {2'b00, e.v, e.p, e.wd, e.wr});
                chk("dut0_state", {{(CW-2){1'b0}}, o0_state}, {{(CW-2){1'b0}}, e.st});
`ifdef PIPE_STAGE_STATS_EN
                chk("dut0_hold_cnt", {{(CW-32){1'b0}}, o0_hold}, {{(CW-32){1'b0}}, e.hc});
                chk("dut0_bubble_cnt", {{(CW-32){1'b0}}, o0_bub}, {{(CW-32){1'b0}}, e.bc});
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("dut1_data", {2'b00, o1_valid, o1_payload, o1_wd, o1_wreg}, {2'b00, e.v, e.p, e.wd, e.wr});
                chk("dut1_state", {{(CW-2){1'b0}}, o1_state}, {{(CW-2){1'b0}}, e.st});
`ifdef PIPE_STAGE_STATS_EN
                chk("dut1_hold_cnt", {{(CW-32){1'b0}}, o1_hold}, {{(CW-32){1'b0}}, e.hc});
                chk("dut1_bubble_cnt", {{(CW-32){1'b0}}, o1_bub}, {{(CW-32){1'b0}}, e.bc});
`endif
            end
        end
    end

    initial begin : driver
        logic [PW-1:0]      p1;
        logic [PAUSE_W-1:0] pz;
        m[0] = '0;
        m[1] = '0;
        rst = 1'b1; flush = 1'b0; pause = '0;
        in_valid = '0; in_payload = '0; in_wd = '0; in_wreg = '0;

        // Reset with all-ones inputs
        cyc(1'b1, 1'b0, '1, '1, '1, '1, '1);
        cyc(1'b1, 1'b0, '1, '1, '1, '1, '1);
        // Pass-through of lane0
        p1 = '0;
        p1[DATA_W-1:0] = 75'h1234;
        cyc(1'b0, 1'b0, 6'b000000, 2'b01, p1, 10'd5, 2'b01);
        // Bubble on stage 2
        cyc(1'b0, 1'b0, 6'b000100, 2'b11, rand_payload(), 10'h3ff, 2'b11);
        // Load something, then hold three cycles with changing inputs
        cyc(1'b0, 1'b0, 6'b000000, 2'b11, rand_payload(), 10'h2a5, 2'b11);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, 1'b0, 6'b001100, 2'($urandom), rand_payload(), 10'($urandom), 2'($urandom));
        // Flush beats hold, then new inputs load
        cyc(1'b0, 1'b1, 6'b001100, 2'b11, rand_payload(), 10'h155, 2'b11);
        cyc(1'b0, 1'b0, 6'b000000, 2'b11, rand_payload(), 10'h0a3, 2'b10);
        // Last stage: pause[5] alone bubbles
        cyc(1'b0, 1'b0, 6'b100000, 2'b11, rand_payload(), 10'h111, 2'b11);
        // Invalid lane drops its write enable
        cyc(1'b0, 1'b0, 6'b000000, 2'b10, rand_payload(), 10'h3e7, 2'b11);
        // Reset mid-hold
        cyc(1'b0, 1'b0, 6'b001100, 2'b11, rand_payload(), 10'h001, 2'b11);
        cyc(1'b1, 1'b0, 6'b001100, 2'b11, rand_payload(), 10'h001, 2'b11);

        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < PAUSE_W; b++) pz[b] = ($urandom_range(0, 2) == 0);
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), pz,
                2'($urandom), rand_payload(), 10'($urandom), 2'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register, the generalised successor of the fixed ID/EX latch. It carries LANES independent instruction slots (payload plus register-write control) from one pipeline stage to the next. It honours the global 6-bit `pause` stall vector for an arbitrary stage index and adds a flush input with per-lane valid tracking. It also drives a registered stage-state output. It is instantiated between every pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in place of per-stage hand-written latches.

## Interface
- `LANES`, 1: number of parallel instruction slots.
- `DATA_W`, 75: payload width per lane (aluop 8 + alusel 3 + reg1 32 + reg2 32).
- `STAGE`, 2: index of this register's upstream stage in `pause`.
- `PAUSE_W`, 6: width of the stall vector.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high (`` `RstEnable ``).
- `pause`  in  PAUSE_W  global stall vector; bit i = `` `Stop `` stalls stage i.
- `flush`  in  1  kill all lanes held in this register (exception/branch-mispredict redirect).
- `in_valid`  in  LANES  per-lane instruction valid.
- `in_payload`  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W].
- `in_wd`  in  LANES*5  destination register address per lane.
- `in_wreg`  in  LANES  register-write enable per lane.
- `out_valid`, `out_payload`, `out_wd`, `out_wreg`  out  same widths  registered copies.
- `stage_state`  out  2  action taken at the last edge: 0 RUN, 1 HOLD, 2 BUBBLE, 3 FLUSH.

## Operation
- The decision is evaluated once per rising edge, in strict priority order:
  1. `rst` high → load NOP into all lanes; `stage_state` = RUN.
  2. `flush` high → load NOP; `stage_state` = FLUSH.
  3. `pause[STAGE]` = Stop and next = NoStop → load NOP (bubble); `stage_state` = BUBBLE.
  4. `pause[STAGE]` = Stop and next = Stop → hold all outputs unchanged; `stage_state` = HOLD.
  5. Otherwise → load inputs; `stage_state` = RUN.
- "next" is `pause[STAGE+1]`. When STAGE = PAUSE_W−1, next is treated as NoStop.
- NOP for a lane means:
  - `out_valid` = 0.
  - `out_payload` = 0, which encodes `` `EXE_NOP_OP `` / `` `EXE_RES_NOP `` / `` `ZeroWord ``.
  - `out_wd` = `` `NOPRegAddr ``.
  - `out_wreg` = `` `WriteDisable ``.
- On a RUN load, a lane with `in_valid` = 0 has `out_wreg` forced to WriteDisable. This way a stale write enable never leaves an invalid slot. Payload and wd still load verbatim.
- All lanes share one decision; there is no per-lane stall.
- Reset values: all `out_*` at NOP, `stage_state` = 0.

## Timing
- Latency: 1 cycle from input to output in RUN.
- HOLD persists for as many cycles as both pause bits stay Stop. The outputs are bit-identical throughout.
- Flush asserted during HOLD wins: outputs go to NOP at that edge, and the held instruction is discarded.
- Flush and a RUN condition in the same cycle: flush wins; the input is dropped.
- `rst` asserted mid-HOLD or mid-FLUSH: NOP at the next edge, with no residual state.
- `stage_state` is registered and aligned with the outputs it describes.

## Configuration
- `PIPE_STAGE_STATS_EN` defined adds two 32-bit counters, `hold_cnt` and `bubble_cnt`:
  - They increment on HOLD and BUBBLE edges respectively.
  - They saturate at 0xFFFF_FFFF and clear on `rst`.
  - They are exposed as extra output ports `hold_cnt` and `bubble_cnt`, for the performance-monitor block.
- Undefined: the counters and their ports are absent, and the block behaves identically otherwise.

## Structure
- Shared package `defs.v` holds:
  - the existing `Stop`/`NoStop`, `RstEnable`, `NOPRegAddr`, `WriteDisable` and `ZeroWord` constants;
  - new `STG_RUN`, `STG_HOLD`, `STG_BUBBLE` and `STG_FLUSH` codes.
- Sub-module `pipe_stage_ctrl` decodes {rst, flush, pause} into the 2-bit action. It is shared by the lane generate loop and the optional stats counters.
- The lane registers are a generate loop over `LANES`.

## Test plan
- Reset: `rst` = 1 with inputs all-ones → after the edge, `out_valid` = 0, `out_payload` = 0, `out_wd` = 0, `out_wreg` = 0, `stage_state` = 0.
- Pass-through: LANES = 2, `pause` = 6'b000000, lane0 payload 0x1234, wd 5, wreg 1 and valid → next edge lane0 outputs match, `stage_state` = RUN.
- Bubble: STAGE = 2, `pause` = 6'b000100 → outputs NOP, `stage_state` = 2. With `PIPE_STAGE_STATS_EN`, `bubble_cnt` = 1.
- Hold: `pause` = 6'b001100 for 3 cycles with changing inputs → outputs frozen at the prior value, `stage_state` = 1 each cycle, `hold_cnt` = 3.
- Flush priority: `flush` = 1 together with `pause` = 6'b001100 → NOP, `stage_state` = 3. Next cycle with `pause` = 0 and `flush` = 0 → new inputs loaded.
- Edge stage and invalid lane:
  - STAGE = 5 with `pause[5]` = 1 → BUBBLE, not HOLD.
  - `in_valid` = 0 with `in_wreg` = 1 → `out_wreg` = 0.
